// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - shared FSM type, default pattern and index-width helper
package seq_pkg;

    typedef enum logic [1:0] {IDLE, GRANT, RUN, DONE} state_e;

    localparam int PAT_W_DEF = 4;
    localparam logic [PAT_W_DEF-1:0] PATTERN_DEF = 4'b0110;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seq_match_core.sv
// rtl/seq_match_core.sv - serial pattern detector with fill tracking and saturating hit counter
module seq_match_core
    import seq_pkg::*;
#(
    parameter int PAT_W = PAT_W_DEF,
    parameter logic [PAT_W-1:0] PATTERN = PATTERN_DEF,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             bit_en,
    input  logic             bit_in,
    output logic             hit,
    output logic [CNT_W-1:0] count_next
);

    localparam int FILL_W = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

    logic [PAT_W-1:0]  shift_q, shift_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic [CNT_W-1:0]  count_q, count_d;

    // hit and count_next reflect the bit being accepted this cycle, so the
    // scheduler can register a final-bit match into done_count directly.
    always_comb begin
        shift_d = shift_q;
        fill_d  = fill_q;
        count_d = count_q;
        hit     = 1'b0;
        if (clr) begin
            shift_d = '0;
            fill_d  = '0;
            count_d = '0;
        end else if (bit_en) begin
            shift_d = {shift_q[PAT_W-2:0], bit_in};
            fill_d  = (fill_q == FILL_FULL) ? fill_q : fill_q + 1'b1;
            hit     = (fill_d == FILL_FULL) && (shift_d == PATTERN);
            if (hit && (count_q != '1)) begin
                count_d = count_q + 1'b1;
            end
        end
        count_next = count_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q <= '0;
            fill_q  <= '0;
            count_q <= '0;
        end else begin
            shift_q <= shift_d;
            fill_q  <= fill_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/seq_match_sched.sv
// rtl/seq_match_sched.sv - round-robin owner of one shared pattern-match engine
module seq_match_sched
    import seq_pkg::*;
#(
    parameter int NCH = 4,
    parameter int PAT_W = PAT_W_DEF,
    parameter logic [PAT_W-1:0] PATTERN = PATTERN_DEF,
    parameter int CNT_W = 8,
    parameter int IDX_W = idx_w(NCH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NCH-1:0]   req,
    input  logic [NCH-1:0]   req_data,
    input  logic [NCH-1:0]   req_valid,
    input  logic [NCH-1:0]   req_last,
    output logic [NCH-1:0]   gnt,
    output logic             match,
    output logic [IDX_W-1:0] match_ch,
    output logic             done,
    output logic [IDX_W-1:0] done_ch,
    output logic [CNT_W-1:0] done_count
);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] ch_q, ch_d;
    logic [NCH-1:0]   gnt_q, gnt_d;
    logic             match_q, match_d;
    logic [IDX_W-1:0] match_ch_q, match_ch_d;
    logic             done_q, done_d;
    logic [IDX_W-1:0] done_ch_q, done_ch_d;
    logic [CNT_W-1:0] done_count_q, done_count_d;

    logic             acc, bit_in, bit_last, core_clr, hit;
    logic [CNT_W-1:0] cnt_next;
    logic [IDX_W-1:0] win;
    int               best_dist;

    // Winner is the requester closest to ptr_q going upward with wrap.
    always_comb begin
        win       = '0;
        best_dist = NCH;
        for (int j = 0; j < NCH; j++) begin
            if (req[j] && (((j - int'(ptr_q) + NCH) % NCH) < best_dist)) begin
                best_dist = (j - int'(ptr_q) + NCH) % NCH;
                win       = IDX_W'(j);
            end
        end
    end

    assign acc      = (state_q == RUN) && req_valid[ch_q];
    assign bit_in   = req_data[ch_q];
    assign bit_last = req_last[ch_q];
    assign core_clr = (state_q == GRANT);

    seq_match_core #(
        .PAT_W   (PAT_W),
        .PATTERN (PATTERN),
        .CNT_W   (CNT_W)
    ) u_core (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (core_clr),
        .bit_en     (acc),
        .bit_in     (bit_in),
        .hit        (hit),
        .count_next (cnt_next)
    );

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        ch_d         = ch_q;
        gnt_d        = gnt_q;
        match_d      = 1'b0;
        match_ch_d   = match_ch_q;
        done_d       = 1'b0;
        done_ch_d    = done_ch_q;
        done_count_d = done_count_q;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d = GRANT;
                    ch_d    = win;
                    ptr_d   = (int'(win) == NCH - 1) ? '0 : win + 1'b1;
                end
            end
            GRANT: begin
                state_d = RUN;
                gnt_d   = NCH'(1) << ch_q;
            end
            RUN: begin
                if (acc) begin
                    match_d = hit;
                    if (hit) begin
                        match_ch_d = ch_q;
                    end
                    if (bit_last) begin
                        state_d      = DONE;
                        gnt_d        = '0;
                        done_d       = 1'b1;
                        done_ch_d    = ch_q;
                        done_count_d = cnt_next;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            ch_q         <= '0;
            gnt_q        <= '0;
            match_q      <= 1'b0;
            match_ch_q   <= '0;
            done_q       <= 1'b0;
            done_ch_q    <= '0;
            done_count_q <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            ch_q         <= ch_d;
            gnt_q        <= gnt_d;
            match_q      <= match_d;
            match_ch_q   <= match_ch_d;
            done_q       <= done_d;
            done_ch_q    <= done_ch_d;
            done_count_q <= done_count_d;
        end
    end

    assign gnt        = gnt_q;
    assign match      = match_q;
    assign match_ch   = match_ch_q;
    assign done       = done_q;
    assign done_ch    = done_ch_q;
    assign done_count = done_count_q;

endmodule

// File: tb/tb_seq_match_sched.sv
// tb/tb_seq_match_sched.sv - frame table plus scoreboard bench for seq_match_sched
module tb_seq_match_sched;

    typedef struct {
        int ch;
        int n;
        int bits;
        int gap;
        int exp_cnt;
        int exp_cnt2;
    } frame_t;

    typedef struct {
        int cyc;
        bit m;
        int mch;
        bit d;
        int dch;
        int dcnt;
        int dcnt2;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req, req_data, req_valid, req_last;
    logic [3:0] gnt, gnt2;
    logic       match, match2, done, done2;
    logic [1:0] match_ch, match_ch2, done_ch, done_ch2;
    logic [7:0] done_count;
    logic [1:0] done_count2;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    ev_t  exp_q[$];
    ev_t  mon_e;
    int   last_dcnt = 0, last_dcnt2 = 0;
    int   last_acc = 0;
    int   hist, fill, cnt8, cnt2;
    frame_t tbl[6];

    seq_match_sched #(.NCH(4), .PAT_W(4), .PATTERN(4'b0110), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data),
        .req_valid(req_valid), .req_last(req_last), .gnt(gnt),
        .match(match), .match_ch(match_ch), .done(done),
        .done_ch(done_ch), .done_count(done_count)
    );

    seq_match_sched #(.NCH(4), .PAT_W(4), .PATTERN(4'b0110), .CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data),
        .req_valid(req_valid), .req_last(req_last), .gnt(gnt2),
        .match(match2), .match_ch(match_ch2), .done(done2),
        .done_ch(done_ch2), .done_count(done_count2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [3:0] onehot(input int c);
        return 4'(1 << c);
    endfunction

    always @(negedge clk) begin
        if (rst_n && (match || done || match2 || done2)) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_event", {30'd0, match, done}, 0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("ev_cycle", cyc, mon_e.cyc);
                chk("match", match, mon_e.m);
                chk("match2", match2, mon_e.m);
                if (mon_e.m) chk("match_ch", match_ch, mon_e.mch);
                chk("done", done, mon_e.d);
                chk("done2", done2, mon_e.d);
                if (mon_e.d) begin
                    chk("done_ch", done_ch, mon_e.dch);
                    chk("done_count", done_count, mon_e.dcnt);
                    chk("done_count2", done_count2, mon_e.dcnt2);
                    last_dcnt  = done_count;
                    last_dcnt2 = done_count2;
                end
            end
        end
    end

    task automatic noise(input logic [3:0] own);
        req_valid = (req_valid & own) | (4'($urandom) & ~own);
        req_data  = (req_data & own)  | (4'($urandom) & ~own);
        req_last  = (req_last & own)  | (4'($urandom) & ~own);
    endtask

    task automatic step(input logic [3:0] own);
        @(posedge clk);
        #1;
        noise(own);
    endtask

    task automatic wait_grant(input int ch, input int c_ref, input int exp_delta);
        int n;
        n = 0;
        while (gnt == 4'd0 && n < 20) begin
            step(4'd0);
            n++;
        end
        chk("gnt_onehot", gnt, onehot(ch));
        chk("gnt_timing", cyc - c_ref, exp_delta);
    endtask

    task automatic drive_bits(input int ch, input int n, input int bits, input int gap);
        logic [3:0] own;
        int i, guard, b;
        bit v, m, is_last;
        ev_t e;
        own = onehot(ch);
        i = 0;
        guard = 0;
        hist = 0; fill = 0; cnt8 = 0; cnt2 = 0;
        while (i < n && guard < 100) begin
            v = (gap == 0) || (guard % 2 == 0);
            req_valid = v ? (req_valid | own) : (req_valid & ~own);
            req_last  = req_last & ~own;
            if (v) begin
                b = (bits >> (n - 1 - i)) & 1;
                is_last = (i == n - 1);
                req_data = (b != 0) ? (req_data | own) : (req_data & ~own);
                if (is_last) req_last = req_last | own;
                hist = ((hist << 1) | b) & 15;
                if (fill < 4) fill++;
                m = (fill == 4) && (hist == 6);
                if (m) begin
                    if (cnt8 < 255) cnt8++;
                    if (cnt2 < 3) cnt2++;
                end
                if (m || is_last) begin
                    e.cyc = cyc + 1; e.m = m; e.mch = ch; e.d = is_last;
                    e.dch = ch; e.dcnt = cnt8; e.dcnt2 = cnt2;
                    exp_q.push_back(e);
                end
                if (is_last) last_acc = cyc + 1;
                i++;
            end
            guard++;
            step(own);
        end
        req_valid = req_valid & ~own;
        req_last  = req_last & ~own;
        chk("gnt_clear_after_last", gnt & own, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        tbl[0] = '{ch: 0, n: 7,  bits: 'h36,  gap: 0, exp_cnt: 2, exp_cnt2: 2};
        tbl[1] = '{ch: 2, n: 4,  bits: 'h6,   gap: 1, exp_cnt: 1, exp_cnt2: 1};
        tbl[2] = '{ch: 1, n: 3,  bits: 'h3,   gap: 0, exp_cnt: 0, exp_cnt2: 0};
        tbl[3] = '{ch: 3, n: 13, bits: 'hDB6, gap: 0, exp_cnt: 4, exp_cnt2: 3};
        tbl[4] = '{ch: 1, n: 8,  bits: 'h66,  gap: 0, exp_cnt: 2, exp_cnt2: 2};
        tbl[5] = '{ch: 2, n: 4,  bits: 'h6,   gap: 0, exp_cnt: 1, exp_cnt2: 1};

        rst_n = 1'b0;
        req = '0; req_data = '0; req_valid = '0; req_last = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_gnt", gnt, 0);
        chk("rst_match", match, 0);
        chk("rst_match_ch", match_ch, 0);
        chk("rst_done", done, 0);
        chk("rst_done_ch", done_ch, 0);
        chk("rst_done_count", done_count, 0);
        chk("rst_done_count2", done_count2, 0);
        rst_n = 1'b1;

        // Fairness: all channels request continuously.
        step(4'd0);
        req = 4'b1111;
        c0 = cyc;
        for (int f = 0; f < 5; f++) begin
            if (f == 0) wait_grant(0, c0, 2);
            else wait_grant(f % 4, last_acc, 3);
            if (f == 4) req = '0;
            drive_bits(f % 4, 4, 6, 0);
        end
        repeat (4) step(4'd0);
        chk("fair_queue_empty", exp_q.size(), 0);

        for (int t = 0; t < 6; t++) begin
            req = onehot(tbl[t].ch);
            c0 = cyc;
            wait_grant(tbl[t].ch, c0, 2);
            req = '0;
            drive_bits(tbl[t].ch, tbl[t].n, tbl[t].bits, tbl[t].gap);
            repeat (4) step(4'd0);
            chk("tbl_queue_empty", exp_q.size(), 0);
            chk("tbl_count", last_dcnt, tbl[t].exp_cnt);
            chk("tbl_count2", last_dcnt2, tbl[t].exp_cnt2);
        end

        // Reset while a frame is running and match is high.
        req = onehot(0);
        c0 = cyc;
        wait_grant(0, c0, 2);
        req = '0;
        for (int i = 0; i < 4; i++) begin
            req_valid = req_valid | 4'b0001;
            req_last  = req_last & 4'b1110;
            req_data  = (((6 >> (3 - i)) & 1) != 0) ? (req_data | 4'b0001) : (req_data & 4'b1110);
            step(4'b0001);
        end
        chk("pre_reset_match", match, 1);
        chk("pre_reset_count", done_count, tbl[5].exp_cnt);
        rst_n = 1'b0;
        #1;
        chk("midrst_gnt", gnt, 0);
        chk("midrst_match", match, 0);
        chk("midrst_done", done, 0);
        chk("midrst_done_count", done_count, 0);
        repeat (2) step(4'd0);
        rst_n = 1'b1;
        req = 4'b1111;
        c0 = cyc;
        wait_grant(0, c0, 2);
        req = '0;
        drive_bits(0, 4, 6, 0);
        repeat (4) step(4'd0);
        chk("final_queue_empty", exp_q.size(), 0);
        chk("final_count", last_dcnt, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_match_sched.md
# seq_match_sched

Round-robin scheduler that shares one serial pattern-match engine among `NCH` bit-stream requesters. A requester holds the engine for a complete frame, from grant until its `last` bit. The block reports each pattern hit while the frame runs, then the total hit count when the frame ends. It sits between the serial input channels and the downstream event/statistics logic, replacing per-channel sequence-detector instances.

## Interface
- `NCH`, 4: number of requesting channels.
- `PAT_W`, 4: pattern length in bits.
- `PATTERN`, 4'b0110: target sequence, MSB is the first bit received.
- `CNT_W`, 8: width of the per-frame match counter.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  reset: asynchronous, active-low.
- `req`  in  NCH  channel i requests the engine for one frame.
- `req_data`  in  NCH  serial data bit per channel.
- `req_valid`  in  NCH  `req_data[i]` is valid this cycle.
- `req_last`  in  NCH  qualifies the final valid bit of the frame.
- `gnt`  out  NCH  one-hot, registered; channel i owns the engine.
- `match`  out  1  one-cycle pulse: the last `PAT_W` accepted bits equal `PATTERN`.
- `match_ch`  out  clog2(NCH)  channel of the current `match`.
- `done`  out  1  one-cycle pulse: the frame has ended.
- `done_ch`  out  clog2(NCH)  channel whose frame ended.
- `done_count`  out  CNT_W  number of matches in the finished frame. Valid with `done`.

## Operation
- FSM states:
  - IDLE → GRANT when any `req` is high.
  - GRANT → RUN after one cycle, which loads `gnt`.
  - RUN → DONE on an accepted bit with `last`.
  - DONE → IDLE after one cycle.
- Arbitration is round-robin.
  - The search starts at (last granted + 1) mod NCH.
  - After reset, the pointer makes channel 0 highest priority.
  - Arbitration is evaluated only in IDLE. Requests arriving during RUN wait.
- Bit acceptance: a bit is accepted only in RUN, when `gnt[i] & req_valid[i]`. Inputs of non-granted channels are ignored.
- Grant hold:
  - The grant is held until `last`, even if `req[i]` drops.
  - `req` is sampled only for arbitration.
- Match rules:
  - A PAT_W-bit shift register and a fill counter (saturating at PAT_W) are cleared in GRANT.
  - A match needs fill == PAT_W and shift == PATTERN after shifting in the accepted bit.
  - Overlapping matches count. For 0110, the stream 0110110 matches twice.
- Counter:
  - The CNT_W counter is cleared in GRANT and increments on each match.
  - It saturates at 2^CNT_W − 1 and never wraps.
- Final bit: when the `last` bit completes a match, `match` and `done` pulse in the same cycle, and `done_count` includes that match.
- Short frame: a frame shorter than PAT_W gives `done` with `done_count` = 0.
- Reset values: `gnt`=0, `match`=0, `match_ch`=0, `done`=0, `done_ch`=0, `done_count`=0; state IDLE; round-robin pointer set for channel 0 first.
- Reset mid-frame: asynchronous clear to the reset values above. No `done` is emitted for the aborted frame.

## Timing
- `req` is seen high in IDLE at edge t. `gnt` is high from edge t+1 (GRANT), and bits are accepted from edge t+2 (RUN).
- A bit accepted at edge k drives `match`/`match_ch` high for cycle k..k+1, registered.
- The `last` bit accepted at edge k:
  - `gnt` clears at edge k.
  - `done`/`done_ch`/`done_count` are high during cycle k..k+1 (DONE).
  - IDLE is reached at k+1, and the earliest next grant is at k+2.
- Frame turnaround: minimum 3 cycles between the last bit of one frame and the first accepted bit of the next.
- `match` and `done` are single-cycle pulses. There is no backpressure; consumers must sample them every cycle.

## Structure
- Package `seq_pkg`:
  - the FSM state enum (IDLE, GRANT, RUN, DONE);
  - the default `PATTERN` and `PAT_W` constants;
  - a `clog2`-based channel-index width helper.
- Sub-module `seq_match_core`: shift register, fill counter, comparator and saturating match counter, with `clr`/`bit_en`/`bit_in` inputs. The scheduler owns arbitration, the FSM, input muxing and output registers.

## Test plan
- Single channel: ch0 sends 0,1,1,0,1,1,0 with `last` on the 7th bit. Required: `match` after bits 4 and 7; `done`, `done_ch`=0, `done_count`=2.
- Fairness: `req`=4'b1111 held after reset, each frame 4 bits. Required: grants in order ch0, ch1, ch2, ch3, ch0, each one-hot, with 3-cycle turnaround.
- Gapped valid: ch2 sends 0110 with `req_valid` low on alternate cycles, while ch1 toggles data/valid without a grant. Required: one match, `match_ch`=2, `done_count`=1, and ch1 has no effect.
- Saturation: with CNT_W=2, a frame of 0110110110110 (4 matches). Required: `done_count`=3.
- Short frame: 0,1,1 with `last` on bit 3. Required: no `match`; `done_count`=0.
- Reset mid-frame: `rst_n` pulses low during RUN. Required: `gnt`, `match`, `done` and `done_count` all clear immediately; no `done` pulse; the next frame is granted to ch0 first.
